// File: rtl/fpu_result_uart_tx.sv
// fpu_result_uart_tx: buffers 16-bit FPU results in a small FIFO and sends each
// one as two 8N1 UART bytes (low byte first) on o_Tx_Serial. The bit period is
// CLKS_PER_BIT clocks (0 behaves as 1), sampled once at the start of every byte.
module fpu_result_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst_l,          // active-high synchronous reset
    input  logic [15:0]      CLKS_PER_BIT,
    input  logic             result_valid,
    input  logic [15:0]      result_data,
    output logic             o_Tx_Serial,
    output logic             o_Tx_Active,
    output logic             o_Tx_Done,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    state_t             state_next;

    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [15:0]        shreg;
    logic [15:0]        cpb;
    logic [15:0]        cpb_in;
    logic [15:0]        timer;
    logic [2:0]         bit_idx;
    logic               byte_sel;
    logic [7:0]         cur_byte;

    logic               pop;
    logic               push;
    logic               bit_end;
    logic               enter_start;

    // A zero bit period would never produce a boundary, so it is clamped to one.
    assign cpb_in      = (CLKS_PER_BIT == 16'd0) ? 16'd1 : CLKS_PER_BIT;
    assign bit_end     = (timer == cpb - 16'd1);
    assign cur_byte    = byte_sel ? shreg[15:8] : shreg[7:0];
    // A full FIFO still accepts a strobe when the transmitter frees a slot that cycle.
    assign push        = result_valid && ((count != CNT_W'(FIFO_DEPTH)) || pop);
    assign enter_start = (state_next == START) && (state != START);

    assign fifo_count  = count;
    assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (result_valid && !push) overflow <= 1'b1;
        end
    end

    // FIFO storage; written only outside reset so strobes during reset leave no trace.
    always_ff @(posedge clk) begin
        if (!rst_l && push) mem[wr_ptr] <= result_data;
    end

    // Word being transmitted; only replaced on a pop, so late strobes cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst_l && pop) shreg <= mem[rd_ptr];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_l) state <= IDLE;
        else       state <= state_next;
    end

    // Bit timer, bit index, byte select and the per-byte latched bit period.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            timer    <= '0;
            cpb      <= 16'd1;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
        end else begin
            if (state == IDLE || bit_end) timer <= '0;
            else                          timer <= timer + 16'd1;

            if (enter_start) cpb <= cpb_in;

            if (state == START)               bit_idx <= '0;
            else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;

            if (pop)                           byte_sel <= 1'b0;
            else if (state == STOP && bit_end) byte_sel <= 1'b1;
        end
    end

    // Next-state logic and line outputs.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        o_Tx_Serial = 1'b1;
        o_Tx_Active = 1'b0;
        o_Tx_Done   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                o_Tx_Serial = 1'b0;
                o_Tx_Active = 1'b1;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                o_Tx_Serial = cur_byte[bit_idx];
                o_Tx_Active = 1'b1;
                if (bit_end && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                o_Tx_Active = 1'b1;
                if (bit_end) begin
                    if (!byte_sel) begin
                        state_next = START;
                    end else begin
                        o_Tx_Done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Testbench for fpu_result_uart_tx: a cycle-level timeline model predicts which
// strobes are kept and when each word leaves the FIFO; a line monitor decodes
// every frame cycle by cycle against the predicted words and bit periods.
module tb_fpu_result_uart_tx;

    localparam int D = 4;

    logic        clk;
    logic        rst_l;
    logic [15:0] CLKS_PER_BIT;
    logic        result_valid;
    logic [15:0] result_data;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        overflow;

    fpu_result_uart_tx #(.FIFO_DEPTH(D), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .result_valid (result_valid),
        .result_data  (result_data),
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    typedef struct {
        logic [15:0] w;
        int          cpb0;
        int          cpb1;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mq[$];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   prints = 0;
    int   next_pop_ok = 0;
    bit   ovf_exp = 0;
    bit   checks_on = 0;
    bit   abort_req = 0;
    int   cpb_old = 4;
    int   cpb_new = 4;
    int   chg_cyc = 32'h3fff_ffff;

    bit   mon_busy = 0;
    exp_t cur;
    int   pos, cnt, ferr, byte_i, bi, cp;
    logic expbit;
    int   frames_done = 0;
    int   unexp = 0;
    int   idle_err = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            if (prints < 40) begin
                prints++;
                $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
            end
        end
    endtask

    function automatic int cpb_at(input int x);
        return (x >= chg_cyc) ? cpb_new : cpb_old;
    endfunction

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic set_cpb(input int v);
        cpb_old = v;
        cpb_new = v;
        chg_cyc = 32'h3fff_ffff;
    endtask

    // One clock: check visible state against the model, drive inputs, advance the model.
    task automatic step(input logic v, input logic [15:0] d, input logic r);
        int   c;
        int   p0;
        int   p1;
        exp_t e;
        c = cyc;
        if (checks_on) begin
            chk("fifo_count", int'(fifo_count), mq.size());
            chk("overflow", int'(overflow), int'(ovf_exp));
            chk("fifo_full", int'(fifo_full), (mq.size() == D) ? 1 : 0);
        end
        rst_l        = r;
        result_valid = v;
        result_data  = d;
        CLKS_PER_BIT = 16'(cpb_at(c));
        if (r) begin
            mq.delete();
            sb.delete();
            ovf_exp     = 0;
            next_pop_ok = c + 1;
            abort_req   = 1;
        end else begin
            if (c >= next_pop_ok && mq.size() > 0) begin
                e.w         = mq.pop_front();
                p0          = eff(cpb_at(c));
                p1          = eff(cpb_at(c + 10 * p0));
                e.cpb0      = p0;
                e.cpb1      = p1;
                e.start_cyc = c + 1;
                sb.push_back(e);
                next_pop_ok = c + 10 * (p0 + p1) + 1;
            end
            if (v) begin
                if (mq.size() < D) mq.push_back(d);
                else               ovf_exp = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((mq.size() != 0 || cyc < next_pop_ok || sb.size() != 0 || mon_busy) && guard < 3000) begin
            step(0, 16'h0, 0);
            guard++;
        end
        if (guard >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain: transmitter still busy after %0d cycles, want idle", guard);
        end
        repeat (3) step(0, 16'h0, 0);
    endtask

    // Line monitor: decodes frames on the falling clock edge.
    always @(negedge clk) begin
        if (abort_req) begin
            mon_busy  = 0;
            abort_req = 0;
        end else if (checks_on) begin
            if (!mon_busy) begin
                if (o_Tx_Serial === 1'b0) begin
                    if (sb.size() == 0) begin
                        unexp++;
                    end else begin
                        cur      = sb.pop_front();
                        mon_busy = 1;
                        pos      = 0;
                        cnt      = 0;
                        ferr     = 0;
                        chk("start_cycle", cyc, cur.start_cyc);
                    end
                end else if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0 || o_Tx_Done !== 1'b0) begin
                    idle_err++;
                end
            end
            if (mon_busy) begin
                byte_i = pos / 10;
                bi     = pos % 10;
                cp     = (byte_i != 0) ? cur.cpb1 : cur.cpb0;
                if (bi == 0)      expbit = 1'b0;
                else if (bi == 9) expbit = 1'b1;
                else              expbit = cur.w[byte_i * 8 + bi - 1];
                if (o_Tx_Serial !== expbit) ferr++;
                if (o_Tx_Active !== 1'b1) ferr++;
                if (o_Tx_Done !== ((pos == 19 && cnt == cp - 1) ? 1'b1 : 1'b0)) ferr++;
                cnt++;
                if (cnt == cp) begin
                    cnt = 0;
                    pos++;
                end
                if (pos == 20) begin
                    mon_busy = 0;
                    frames_done++;
                    total++;
                    if (ferr != 0) begin
                        bad++;
                        $display("FAIL frame word=%h: %0d bad line cycles, want 0", cur.w, ferr);
                    end
                end
            end
        end
    end

    initial begin
        int fd;
        rst_l        = 1;
        result_valid = 0;
        result_data  = 0;
        CLKS_PER_BIT = 16'd4;
        @(posedge clk);
        #1;

        // Reset, with a strobe that must be ignored.
        step(0, 16'h0, 1);
        step(1, 16'hDEAD, 1);
        checks_on = 1;
        chk("rst_serial", int'(o_Tx_Serial), 1);
        chk("rst_active", int'(o_Tx_Active), 0);
        chk("rst_done", int'(o_Tx_Done), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_full", int'(fifo_full), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Single word at 4 clocks per bit.
        set_cpb(4);
        fd = frames_done;
        step(1, 16'hA53C, 0);
        drain();
        chk("t1_frames", frames_done - fd, 1);

        // Burst of six at 2 clocks per bit: first pops, four fill, sixth is dropped.
        set_cpb(2);
        fd = frames_done;
        for (int i = 1; i <= 6; i++) step(1, 16'(i), 0);
        chk("t2_overflow", int'(overflow), 1);
        drain();
        chk("t2_frames", frames_done - fd, 5);
        step(0, 16'h0, 1);

        // Full FIFO receiving a strobe in the same cycle as the idle pop.
        set_cpb(2);
        fd = frames_done;
        for (int i = 0; i < 5; i++) step(1, 16'h1000 + 16'(i), 0);
        for (int g = 0; g < 200 && cyc < next_pop_ok; g++) step(0, 16'h0, 0);
        step(1, 16'h2000, 0);
        chk("t3_count", int'(fifo_count), 4);
        chk("t3_overflow", int'(overflow), 0);
        drain();
        chk("t3_frames", frames_done - fd, 6);

        // Zero bit period behaves as one clock per bit.
        set_cpb(0);
        fd = frames_done;
        step(1, 16'h5A96, 0);
        drain();
        chk("t4_frames", frames_done - fd, 1);

        // Reset in the middle of the first data byte with two words queued.
        set_cpb(4);
        fd = frames_done;
        step(1, 16'h1111, 0);
        step(1, 16'h2222, 0);
        step(1, 16'h3333, 0);
        repeat (6) step(0, 16'h0, 0);
        chk("t5_pre_active", int'(o_Tx_Active), 1);
        step(0, 16'h0, 1);
        chk("t5_serial", int'(o_Tx_Serial), 1);
        chk("t5_count", int'(fifo_count), 0);
        chk("t5_active", int'(o_Tx_Active), 0);
        repeat (100) step(0, 16'h0, 0);
        chk("t5_frames", frames_done - fd, 0);

        // Bit period raised from 4 to 8 while byte 0 is on the line.
        set_cpb(4);
        fd = frames_done;
        cpb_new = 8;
        chg_cyc = cyc + 20;
        step(1, 16'hC3A5, 0);
        drain();
        set_cpb(8);
        chk("t6_frames", frames_done - fd, 1);

        // Randomized traffic with varying bit periods.
        for (int g = 0; g < 5; g++) begin
            set_cpb(int'($urandom_range(0, 3)));
            repeat (25) step(($urandom_range(0, 2) == 0), 16'($urandom), 0);
            drain();
        end

        chk("unexpected_starts", unexp, 0);
        chk("idle_errs", idle_err, 0);
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_result_uart_tx.md
Name: fpu_result_uart_tx

Overview:
Downstream consumer of the FPU top-level 16-bit half-precision result.
- Captures each result on a one-cycle valid strobe into a small FIFO.
- Serializes each result as two 8N1 UART bytes, low byte first, on a TX pin.
- Uses the same CLKS_PER_BIT baud control as the programming UART receiver, so a host can read back FPU results over the serial link it already uses to load programs.

Parameters:
FIFO_DEPTH, 4, number of 16-bit results buffered; power of two, minimum 2.
CNT_W, 3, width of the FIFO occupancy counter; must hold FIFO_DEPTH, i.e. log2(FIFO_DEPTH)+1.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_l  input  1  synchronous reset, active-high (asserted = 1, sampled on clk), despite the codebase port name.
CLKS_PER_BIT  input  16  clk cycles per UART bit; 0 treated as 1.
result_valid  input  1  one-cycle strobe, result_data is valid.
result_data  input  16  FPU half-precision result.
o_Tx_Serial  output  1  UART TX line; idle high.
o_Tx_Active  output  1  high while a frame, from start bit through stop bit, is on the line.
o_Tx_Done  output  1  one-cycle pulse when the second byte's stop bit completes.
fifo_full  output  1  occupancy == FIFO_DEPTH.
fifo_count  output  CNT_W  current occupancy.
overflow  output  1  sticky; set when a strobe is dropped.

Behaviour:
Reset (rst_l == 1 at an edge):
- o_Tx_Serial=1; o_Tx_Active=0; o_Tx_Done=0; fifo_full=0; fifo_count=0; overflow=0.
- FIFO pointers = 0; FSM = IDLE.
- Any in-flight frame is abandoned. The line is high from the cycle after the reset edge.

FIFO:
- Push when result_valid and (count < FIFO_DEPTH, or a pop occurs in the same cycle).
- Pop occurs on the IDLE->START transition. Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- result_valid while full with no same-cycle pop: the data is dropped and overflow is set to 1 until reset.

Shift register: holds the popped 16-bit word; byte_sel selects [7:0] first, then [15:8].

Bit timer:
- Counts 0..CPB-1, where CPB = max(CLKS_PER_BIT, 1).
- A bit boundary is the cycle where the timer reaches CPB-1.
- CLKS_PER_BIT is sampled at the start of each byte, i.e. entry to START, and held for that byte.

FSM states and transitions:
- IDLE: o_Tx_Serial=1. If count != 0: pop, load the shift register, byte_sel=0, go to START.
- START: o_Tx_Serial=0 for CPB cycles, then go to DATA with bit_idx=0.
- DATA: o_Tx_Serial = current byte[bit_idx], LSB first, CPB cycles per bit. After bit 7, go to STOP.
- STOP: o_Tx_Serial=1 for CPB cycles, then:
  - if byte_sel=0: set byte_sel=1, go to START (no idle gap);
  - else: assert o_Tx_Done for that one cycle and go to IDLE.
- o_Tx_Active = (state is START, DATA or STOP).

Latency and throughput:
- Strobe at cycle 0 with FIFO empty and FSM in IDLE: count=1 at cycle 1; IDLE->START edge at the end of cycle 1; start bit on the line from cycle 2.
- One result occupies exactly 20*CPB cycles on the line.
- The next FIFO entry pops in the cycle after o_Tx_Done, giving one idle-high cycle between results.

Boundary conditions:
- A strobe arriving during transmission is only buffered. It never corrupts the word in the shift register.
- A CLKS_PER_BIT change mid-byte takes effect at the next byte.
- result_valid during reset is ignored.

Test Plan:
- CPB=4, strobe 16'hA53C once. Required line sequence from cycle 2:
  - byte 0x3C: start 0 (4 cycles), then bits 0,0,1,1,1,1,0,0 (4 cycles each), then stop 1;
  - byte 0xA5: start, then bits 1,0,1,0,0,1,0,1, then stop;
  - o_Tx_Done pulses at cycle 81; o_Tx_Active is high for cycles 2..81.
- CPB=2, five strobes 16'h0001..16'h0005 on consecutive cycles with FIFO_DEPTH=4:
  - 0x0001 is popped during the burst, so all five are accepted and overflow stays 0;
  - a sixth back-to-back strobe sets overflow=1 and is dropped;
  - transmitted words are 0001,0002,0003,0004,0005 in that order.
- Full FIFO with a strobe in the same cycle as an IDLE pop: the strobe is accepted, fifo_count stays 4, overflow stays 0.
- CLKS_PER_BIT=0: each bit lasts 1 cycle; one word takes 20 cycles of line time.
- rst_l=1 asserted mid-DATA of the first byte, with 2 entries queued:
  - next cycle: o_Tx_Serial=1, fifo_count=0, o_Tx_Active=0;
  - no further frames until a new strobe arrives.
- CPB changed from 4 to 8 during byte 0 of a word: byte 0 completes at 4 cycles per bit; byte 1 runs at 8 cycles per bit.
